posit_mul_sched: RTL
====================

// Module: posit_mul_sched
// PURPOSE
//  Shares one combinational posit multiplier among NREQ requesters, using round-robin arbitration.
//  Each request is a pair of posit operands; each completion returns the product tagged with the requester id.
//  Zero and NaR operands are resolved here and never reach the multiplier datapath.
//  Sits between the posit issue logic and the multiplier core; it is the only owner of that core.
// PARAMETERS
//  BITS     32  posit width
//  ES       3   exponent field width, passed to the multiplier
//  NREQ     4   number of requesters (>=2)
//  MUL_LAT  1   cycles allowed for the multiplier output to settle before capture (>=1)
//  IDW      2   requester id width, = $clog2(NREQ)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous reset, active-high
//  req_valid   in   NREQ       per-requester request valid
//  req_ready   out  NREQ       per-requester accept; one-hot or zero
//  req_x       in   NREQ*BITS  operand x; requester i uses [i*BITS +: BITS]
//  req_y       in   NREQ*BITS  operand y; same packing as req_x
//  resp_valid  out  1          product available
//  resp_ready  in   1          consumer accepts the product
//  resp_id     out  IDW        requester that owns the product
//  resp_posit  out  BITS       product (posit encoding)
//  busy        out  1          high whenever state != IDLE
//  ops_done    out  32         count of completed responses; wraps at 2^32
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_posit=0, ops_done=0, busy=0.
//   req_ready is forced 0 while rst=1.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//   - Grant g = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
//   - req_ready[g]=1 in that cycle (combinational); a transfer occurs when valid&ready.
//   - On transfer, latch op_x, op_y and id=g; load cnt=MUL_LAT-1; go to CALC.
//   - No valid requests: stay in IDLE.
//  CALC:
//   - op_x and op_y drive the multiplier core.
//   - Each cycle, if cnt!=0 then cnt--; otherwise capture the result and go to DONE.
//   - Result mux, in priority order:
//     - op_x or op_y == NaR (1 followed by BITS-1 zeros): result = NaR.
//     - op_x or op_y == 0: result = 0.
//     - otherwise: result = multiplier output.
//   - Special cases take the same latency as normal products (uniform timing).
//  DONE:
//   - resp_valid=1; resp_id and resp_posit are held stable until resp_ready=1.
//   - On the accept edge: resp_valid->0, ops_done++, rr_ptr=(id+1) mod NREQ, go to IDLE.
//  Timing and rules:
//   - Latency: request accepted in cycle t -> resp_valid first high in cycle t+1+MUL_LAT.
//   - Throughput: at most one product every MUL_LAT+2 cycles.
//   - req_ready is 0 in CALC and DONE; requesters must hold valid and operands until accepted.
//   - The resp_ready=1 cycle in DONE is the IDLE-return cycle, so no new grant is issued in it.
//  Boundary conditions:
//   - Simultaneous requests: only the granted requester sees ready; the others wait.
//   - Fairness: a requester waits at most NREQ-1 grants before being served.
//   - rr_ptr wrap-around: after id=NREQ-1 the next search starts at 0.
//   - Reset mid-operation (CALC or DONE): in-flight operation is dropped with no response,
//     ops_done is cleared, and the FSM is in IDLE on the next cycle.
//   - resp_ready high in IDLE or CALC: ignored.
//   - req_valid dropped before grant: legal; nothing is latched.
//   - Operand sign handling, including 2's-complement negation, stays inside the multiplier core.
// STRUCTURE
//  Package posit_pkg holds:
//   - state encoding (ST_IDLE, ST_CALC, ST_DONE);
//   - functions is_nar(bits) and is_zero(bits);
//   - POSIT_NAR and POSIT_ZERO, parameterised by BITS.
//  Sub-module posit_rr_arbiter (NREQ, IDW):
//   - inputs: req vector, rr_ptr;
//   - outputs: one-hot grant, gnt_id, any_req;
//   - purely combinational.
//  One multiplier core instance (BITS, ES); its inputs come only from op_x and op_y.
// TESTING
//  1. Single request: req_valid[0]=1, x=y=0x40000000 (1.0) -> resp_valid in cycle t+2,
//     resp_id=0, resp_posit=0x40000000.
//  2. Normal product: x=y=0x44000000 (2.0, ES=3) -> resp_posit=0x48000000 (4.0); ops_done=1.
//  3. Special values: x=0x80000000 with y=0 -> NaR; x=0 with y=0x44000000 -> 0x00000000;
//     both take the same latency as case 2.
//  4. Fairness: all 4 requesters valid continuously -> resp_id sequence 0,1,2,3,0.
//     Each grant is one-hot, and req_ready=0 outside IDLE.
//  5. Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_valid, resp_id and
//     resp_posit stable; no req_ready pulses.
//  6. Reset mid-CALC: rst=1 for 1 cycle -> no response, ops_done=0, busy=0.
//     The next request completes normally, with rr_ptr=0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared definitions for the posit multiply scheduler.
//  - state_t   : scheduler FSM encoding
//  - POSIT_NAR / POSIT_ZERO : special encodings at the reference width
//  - is_nar / is_zero       : special-value detectors, usable at any width
//                             up to POSIT_MAXW (operand zero-extended)
package posit_pkg;

    localparam int POSIT_BITS = 32;
    localparam int POSIT_MAXW = 64;

    localparam logic [POSIT_BITS-1:0] POSIT_NAR  = {1'b1, {(POSIT_BITS-1){1'b0}}};
    localparam logic [POSIT_BITS-1:0] POSIT_ZERO = {POSIT_BITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // NaR is a one in the top bit of a width-bit posit and zeros below.
    function automatic logic is_nar(input logic [POSIT_MAXW-1:0] bits,
                                    input int unsigned width);
        return bits == (POSIT_MAXW'(1) << (width - 32'd1));
    endfunction

    function automatic logic is_zero(input logic [POSIT_MAXW-1:0] bits);
        return bits == {POSIT_MAXW{1'b0}};
    endfunction

endpackage

// File: rtl/posit_mul_core.sv
// Combinational posit multiplier (round to nearest even, saturating to
// maxpos/minpos). Zero and NaR are not handled; the caller resolves them.
//  x, y  in   BITS  posit operands
//  p     out  BITS  posit product
module posit_mul_core #(
    parameter int BITS = 32,
    parameter int ES   = 3
) (
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] y,
    output logic [BITS-1:0] p
);

    localparam int FB = BITS - 1 - ES;          // stored fraction bits (max)
    localparam int MW = FB + 1;                 // mantissa incl. hidden one
    localparam int PW = 2 * MW;                 // raw product width
    localparam int FW = PW - 1;                 // normalised product fraction
    localparam int LW = 2 + ES + FW + BITS;     // encode vector, room for shift
    localparam int SW = 16;                     // scale width
    localparam logic signed [SW-1:0] KMAX = SW'(BITS - 3);
    localparam logic signed [SW-1:0] KMIN = SW'(2 - BITS);

    // Returns {scale, 1.fraction}; fraction left-aligned, zero padded.
    function automatic logic [SW+MW-1:0] decode(input logic [BITS-1:0] v);
        logic [BITS-2:0] rem;
        logic [BITS-2:0] inv;
        logic [BITS-2:0] sh;
        logic [SW-1:0]   run;
        logic [SW-1:0]   k;
        logic            found;
        rem   = v[BITS-1] ? (~v[BITS-2:0] + (BITS-1)'(1)) : v[BITS-2:0];
        inv   = rem[BITS-2] ? ~rem : rem;
        run   = {SW{1'b0}};
        found = 1'b0;
        // Regime run length = leading zeros of inv.
        for (int i = BITS - 2; i >= 0; i--) begin
            run   = run + {{(SW-1){1'b0}}, ~(found | inv[i])};
            found = found | inv[i];
        end
        k  = rem[BITS-2] ? (run - 16'd1) : (16'd0 - run);
        sh = rem << (run + 16'd1);
        return {(k << ES) + {{(SW-ES){1'b0}}, sh[BITS-2 -: ES]}, 1'b1, sh[FB-1:0]};
    endfunction

    logic [SW+MW-1:0]       dx_s;
    logic [SW+MW-1:0]       dy_s;
    logic [PW-1:0]          pm_s;
    logic [FW-1:0]          frac_s;
    logic [SW-1:0]          sc_s;
    logic signed [SW-1:0]   k_s;
    logic [SW-1:0]          amt_s;
    logic signed [LW-1:0]   vec_s;
    logic [LW-1:0]          sh_s;
    logic [BITS-2:0]        body_s;
    logic                   rnd_s;
    logic [BITS-1:0]        mag_s;

    // Decode, multiply, normalise, re-encode and round.
    always_comb begin
        dx_s   = decode(x);
        dy_s   = decode(y);
        pm_s   = {{MW{1'b0}}, dx_s[MW-1:0]} * {{MW{1'b0}}, dy_s[MW-1:0]};
        // Product of two [1,2) mantissas lies in [1,4); top bit means >= 2.
        frac_s = pm_s[PW-1] ? pm_s[PW-2:0] : {pm_s[PW-3:0], 1'b0};
        sc_s   = dx_s[SW+MW-1:MW] + dy_s[SW+MW-1:MW] + {{(SW-1){1'b0}}, pm_s[PW-1]};
        k_s    = $signed(sc_s) >>> ES;
        // k>=0: k+1 ones then 0; k<0: -k zeros then 1. Arithmetic shift
        // replicates the leading regime bit to build the run.
        amt_s  = k_s[SW-1] ? ~k_s : k_s;
        vec_s  = {(k_s[SW-1] ? 2'b01 : 2'b10), sc_s[ES-1:0], frac_s, {BITS{1'b0}}};
        sh_s   = vec_s >>> amt_s;
        rnd_s  = sh_s[LW-BITS] & ((|sh_s[LW-BITS-1:0]) | sh_s[LW-BITS+1]);
        // Body always contains a zero here, so rounding up cannot overflow.
        body_s = sh_s[LW-1 -: BITS-1] + {{(BITS-2){1'b0}}, rnd_s};
        if (k_s > KMAX) begin
            body_s = {(BITS-1){1'b1}};
        end else if (k_s < KMIN) begin
            body_s = {{(BITS-2){1'b0}}, 1'b1};
        end else begin
            body_s = body_s;
        end
        mag_s = {1'b0, body_s};
        p     = (x[BITS-1] ^ y[BITS-1]) ? (~mag_s + {{(BITS-1){1'b0}}, 1'b1}) : mag_s;
    end

endmodule

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//  req     in   NREQ  request vector
//  rr_ptr  in   IDW   index that has highest priority this cycle
//  grant   out  NREQ  one-hot grant (zero when no request)
//  gnt_id  out  IDW   index of the granted requester
//  any_req out  1     at least one request present
module posit_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            any_req
);

    assign any_req = |req;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int   idx;
        logic found;
        grant  = {NREQ{1'b0}};
        gnt_id = {IDW{1'b0}};
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!found && req[idx[IDW-1:0]]) begin
                grant[idx[IDW-1:0]] = 1'b1;
                gnt_id              = idx[IDW-1:0];
                found               = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/posit_mul_sched.sv
// Shares one posit multiplier among NREQ requesters with round-robin
// arbitration; zero and NaR operands are resolved locally.
//  clk, rst            clock, synchronous active-high reset
//  req_valid/req_ready per-requester handshake (ready one-hot or zero)
//  req_x, req_y        packed operands, requester i at [i*BITS +: BITS]
//  resp_valid/ready    product handshake; resp_id, resp_posit held until accepted
//  busy                FSM not idle
//  ops_done            completed responses, wrapping
module posit_mul_sched
    import posit_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int ES      = 3,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*BITS-1:0] req_x,
    input  logic [NREQ*BITS-1:0] req_y,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [BITS-1:0]    resp_posit,
    output logic               busy,
    output logic [31:0]        ops_done
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_LAT - 1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam logic [BITS-1:0] NAR_VAL  = {1'b1, {(BITS-1){1'b0}}};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  gnt_id_s;
    logic [NREQ-1:0] grant_s;
    logic            any_req_s;
    logic [BITS-1:0] op_x_r;
    logic [BITS-1:0] op_y_r;
    logic [BITS-1:0] mul_p_s;
    logic [BITS-1:0] result_s;
    logic [CW-1:0]   cnt_r;

    posit_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_r),
        .grant   (grant_s),
        .gnt_id  (gnt_id_s),
        .any_req (any_req_s)
    );

    posit_mul_core #(.BITS(BITS), .ES(ES)) u_mul (
        .x (op_x_r),
        .y (op_y_r),
        .p (mul_p_s)
    );

    assign busy = (state_r != ST_IDLE);

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        if (state_r == ST_IDLE && !rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Special operands override the core; NaR takes priority over zero.
    always_comb begin
        if (is_nar(POSIT_MAXW'(op_x_r), 32'(BITS)) || is_nar(POSIT_MAXW'(op_y_r), 32'(BITS))) begin
            result_s = NAR_VAL;
        end else if (is_zero(POSIT_MAXW'(op_x_r)) || is_zero(POSIT_MAXW'(op_y_r))) begin
            result_s = {BITS{1'b0}};
        end else begin
            result_s = mul_p_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nxt_s = ST_CALC;
                else           state_nxt_s = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == {CW{1'b0}}) state_nxt_s = ST_DONE;
                else                     state_nxt_s = ST_CALC;
            end
            ST_DONE: begin
                if (resp_ready) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand capture, settle counter, response registers and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= {IDW{1'b0}};
            id_r       <= {IDW{1'b0}};
            op_x_r     <= {BITS{1'b0}};
            op_y_r     <= {BITS{1'b0}};
            cnt_r      <= {CW{1'b0}};
            resp_valid <= 1'b0;
            resp_id    <= {IDW{1'b0}};
            resp_posit <= {BITS{1'b0}};
            ops_done   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        op_x_r <= req_x[int'(gnt_id_s)*BITS +: BITS];
                        op_y_r <= req_y[int'(gnt_id_s)*BITS +: BITS];
                        id_r   <= gnt_id_s;
                        cnt_r  <= CNT_LOAD;
                    end
                end
                ST_CALC: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_r;
                        resp_posit <= result_s;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_done   <= ops_done + 32'd1;
                        rr_ptr_r   <= (id_r == LAST_ID) ? {IDW{1'b0}}
                                                        : id_r + {{(IDW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
